data_mem_mmio: RTL and testbench
================================

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 Parameter DMEM_BASE, default 32'h1000_0000: byte base address of the data RAM.
REQ-002 Parameter DMEM_AW, default 15: log2 of the RAM depth in 32-bit words (128 KiB at default).
REQ-003 Parameter UART_TX_ADDR, default 32'h2000_0000: the transmit-data register (write-only).
REQ-004 Parameter UART_STAT_ADDR, default 32'h2000_0004: the status register (read-only).
REQ-005 Parameter TXQ_DEPTH, default 8: UART transmit queue depth; must be a power of two and at least 2.
REQ-006 Parameter INIT_FILE, default "data.hex": simulation-only $readmemh image for the RAM.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port req_valid, input, 1 bit: a request is present.
REQ-010 Port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-011 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-012 Port req_addr, input, 32 bits: byte address.
REQ-013 Port req_wdata, input, 32 bits: store data, right-aligned.
REQ-014 Port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-015 Port req_signed, input, 1 bit: sign-extend the load result.
REQ-016 Port rsp_valid, output, 1 bit: load data is valid.
REQ-017 Port rsp_rdata, output, 32 bits: load result.
REQ-018 Port tx_valid, output, 1 bit: a UART byte is available.
REQ-019 Port tx_data, output, 8 bits: the UART byte at the head of the queue.
REQ-020 Port tx_ready, input, 1 bit: the downstream UART consumes the byte.
REQ-021 Port fault, output, 1 bit: sticky access-error flag.
REQ-022 Port fault_addr, output, 32 bits: address of the first faulting access.
REQ-023 Port fault_clr, input, 1 bit: clears fault.

Function
REQ-024 A request is accepted on a rising edge when req_valid and req_ready are both high.
REQ-025 req_ready is low only when the request is a store to UART_TX_ADDR and the queue is full; otherwise it is high.
REQ-026 A store to the RAM commits at the accepting edge, writing only its enabled bytes.
  - SB writes byte addr[1:0]; SH writes half addr[1]; SW writes the full word.
REQ-027 A load produces rsp_valid = 1 for exactly one cycle, on the cycle after acceptance (latency 1).
  - Stores never assert rsp_valid.
REQ-028 A load issued on the cycle after a store to the same word returns the updated data (read-after-write coherent).
REQ-029 Byte and half loads select by addr[1:0] / addr[1].
  - The result is zero-extended, or sign-extended when req_signed = 1.
REQ-030 A load from UART_STAT_ADDR returns {24'b0, count[5:0], full, empty}; count is zero-padded.
REQ-031 An accepted SB or SW to UART_TX_ADDR pushes wdata[7:0] into the queue.
REQ-032 The queue pops when tx_valid and tx_ready are both high.
  - tx_valid = !empty; tx_data is the head entry; no bypass from empty.
  - When the queue is full, a simultaneous pop does not raise req_ready in the same cycle.
  - Pointers wrap modulo TXQ_DEPTH; count runs 0..TXQ_DEPTH.
REQ-033 Fault conditions are:
  - an address outside the RAM and the UART registers;
  - a load from UART_TX_ADDR or a store to UART_STAT_ADDR;
  - a misaligned half or word access;
  - req_size = 11.
REQ-034 A faulting request is still accepted, changes no RAM or queue state, and a faulting load returns rsp_rdata = 0 with rsp_valid asserted.
REQ-035 fault_addr captures the address only while fault = 0.
  - fault_clr alone clears fault on the next edge.
  - When a new fault coincides with fault_clr, fault stays 1 and fault_addr takes the new address.
REQ-036 rsp_rdata holds its value when rsp_valid = 0.

Reset
REQ-037 When rst_n = 0:
  - rsp_valid = 0, rsp_rdata = 0, fault = 0, fault_addr = 0;
  - the queue is empty (tx_valid = 0, tx_data = 0);
  - req_ready = 1.
REQ-038 Reset asserted mid-operation drops any pending response and all queued bytes.
REQ-039 RAM contents are not reset; in simulation the RAM loads from INIT_FILE at time 0.

Structure
REQ-040 Shared package mem_pkg holds the size encodings and the default address-map constants.
REQ-041 The transmit queue is a separate sub-module, sync_fifo, parametrised by WIDTH and DEPTH and exposing count, full and empty.
REQ-042 The RAM is a single inferred array of 2**DMEM_AW words with byte-enable writes; synthesis excludes INIT_FILE loading.

Verification
REQ-043 Byte store then signed load:
  - SB 0x80 to 0x1000_0003, then LB 0x1000_0003 -> rsp_rdata = 0xFFFF_FF80 one cycle after acceptance;
  - the same access with LBU -> 0x0000_0080.
REQ-044 Mixed-width read-back: SW 0x1234_5678 to 0x1000_0010, SH 0xBEEF to 0x1000_0012, then LW -> 0xBEEF_5678.
REQ-045 Queue fill and drain:
  - with tx_ready = 0, after 8 UART stores 'A'..'H', the 9th store sees req_ready = 0;
  - the status read then returns 0x22;
  - raising tx_ready drains A..H in order, with the stalled 9th byte following.
REQ-046 Fault capture and clear:
  - LW 0x1000_0002 -> fault = 1, fault_addr = 0x1000_0002, rsp_rdata = 0;
  - a later SW 0x3000_0000 leaves fault_addr unchanged;
  - fault_clr together with a new faulting access keeps fault = 1 and updates fault_addr.
REQ-047 Reset with work in flight: assert rst_n low with 3 queued bytes and a pending load -> tx_valid = 0 and rsp_valid = 0 immediately, and RAM data is preserved.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared size encodings, default address map and load helpers
// for the data memory / UART MMIO slice.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  localparam logic [31:0] DMEM_BASE_DEF = 32'h1000_0000;
  localparam int          DMEM_AW_DEF   = 15;
  localparam logic [31:0] UART_TX_DEF   = 32'h2000_0000;
  localparam logic [31:0] UART_STAT_DEF = 32'h2000_0004;

  function automatic logic misaligned(
    logic [1:0] sz,
    logic [1:0] a
  );
    return (sz == SZ_H && a[0]) ||
           (sz == SZ_W && a != 2'b00);
  endfunction

  function automatic logic [31:0] load_ext(
    logic [31:0] w,
    logic [1:0]  off,
    logic [1:0]  sz,
    logic        sgn
  );
    logic [31:0] s;
    logic [31:0] r;
    s = w >> {off, 3'b000};
    case (sz)
      SZ_B:    r = {{24{sgn & s[7]}}, s[7:0]};
      SZ_H:    r = {{16{sgn & s[15]}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head is zero when empty
// so the consumer never sees stale entries.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data RAM with byte-enable stores plus a UART transmit queue
// and status register, with a sticky access-fault capture.
module data_mem_mmio
  import mem_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE      = DMEM_BASE_DEF,
  parameter int          DMEM_AW        = DMEM_AW_DEF,
  parameter logic [31:0] UART_TX_ADDR   = UART_TX_DEF,
  parameter logic [31:0] UART_STAT_ADDR = UART_STAT_DEF,
  parameter int          TXQ_DEPTH      = 8,
  parameter string       INIT_FILE      = "data.hex"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        fault,
  output logic [31:0] fault_addr,
  input  logic        fault_clr
);

  localparam int QAW = $clog2(TXQ_DEPTH);
  localparam int RW  = DMEM_AW + 2;

  logic [31:0]        offs;
  logic [DMEM_AW-1:0] widx;
  logic               in_ram;
  logic               is_tx;
  logic               is_stat;
  logic               bad;
  logic               acc;
  logic               flt;
  logic               ram_we;
  logic               ld_acc;
  logic               q_push;
  logic               q_pop;
  logic               q_full;
  logic               q_empty;
  logic [QAW:0]       q_count;
  logic [7:0]         stat_b;
  logic [3:0]         be;
  logic [31:0]        wd;

  assign offs    = req_addr - DMEM_BASE;
  assign in_ram  = (offs >> RW) == '0;
  assign widx    = offs[RW-1:2];
  assign is_tx   = req_addr == UART_TX_ADDR;
  assign is_stat = req_addr == UART_STAT_ADDR;

  assign req_ready = !(req_valid && req_we &&
                       is_tx && q_full);
  assign acc       = req_valid && req_ready;

  assign bad = req_size == SZ_X ||
               misaligned(req_size, req_addr[1:0]) ||
               !(in_ram || is_tx || is_stat) ||
               (is_tx && !req_we) ||
               (is_stat && req_we);

  assign flt    = acc && bad;
  assign ram_we = acc && req_we && in_ram && !bad;
  assign ld_acc = acc && !req_we;
  assign q_push = acc && req_we && is_tx && !bad &&
                  req_size != SZ_H;
  assign q_pop  = tx_valid && tx_ready;
  assign stat_b = {6'(q_count), q_full, q_empty};

  always_comb begin
    be = 4'b1111;
    wd = req_wdata;
    unique case (1'b1)
      req_size == SZ_B: begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      req_size == SZ_H: begin
        be = req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  logic [31:0] ram [2**DMEM_AW];
  logic [31:0] rd_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[widx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
    if (ld_acc) rd_q <= ram[widx];
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .wdata (req_wdata[7:0]),
    .pop   (q_pop),
    .rdata (tx_data),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign tx_valid = !q_empty;

  logic        rsp_v_q;
  logic        src_flt_q;
  logic        src_stat_q;
  logic [1:0]  off_q;
  logic [1:0]  sz_q;
  logic        sgn_q;
  logic [7:0]  stat_q;
  logic [31:0] hold_q;
  logic [31:0] rsp_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v_q    <= 1'b0;
      src_flt_q  <= 1'b0;
      src_stat_q <= 1'b0;
      off_q      <= '0;
      sz_q       <= '0;
      sgn_q      <= 1'b0;
      stat_q     <= '0;
      hold_q     <= '0;
    end else begin
      rsp_v_q <= ld_acc;
      if (ld_acc) begin
        src_flt_q  <= bad;
        src_stat_q <= is_stat && !bad;
        off_q      <= req_addr[1:0];
        sz_q       <= req_size;
        sgn_q      <= req_signed;
        stat_q     <= stat_b;
      end
      if (rsp_v_q) hold_q <= rsp_word;
    end
  end

  always_comb begin
    rsp_word = load_ext(rd_q, off_q, sz_q, sgn_q);
    unique case (1'b1)
      src_flt_q:  rsp_word = '0;
      src_stat_q: rsp_word = load_ext({24'b0, stat_q},
                                      off_q, sz_q, sgn_q);
      default: ;
    endcase
  end

  assign rsp_valid = rsp_v_q;
  assign rsp_rdata = rsp_v_q ? rsp_word : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (flt) begin
      fault <= 1'b1;
      if (!fault || fault_clr) fault_addr <= req_addr;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed vectors,
// queue/fault/reset sequences and a randomized model run.
module tb_data_mem_mmio;
  import mem_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] TXA  = 32'h2000_0000;
  localparam logic [31:0] STA  = 32'h2000_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        fault;
  logic [31:0] fault_addr;
  logic        fault_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  data_mem_mmio #(.INIT_FILE("")) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fault_clr  (fault_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Behavioural model: byte map, byte queue, fault flag/address.
  logic [7:0]  mm [int unsigned];
  logic [7:0]  txq [$];
  logic        mf;
  logic [31:0] mfa;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void mstore(logic [31:0] a,
                                 logic [31:0] d,
                                 logic [1:0] sz);
    int n = 1 << sz;
    for (int k = 0; k < n; k++) mm[a + k] = d[8*k +: 8];
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a,
                                           logic [1:0] sz,
                                           logic sg);
    int n = 1 << sz;
    longint unsigned v = 0;
    for (int k = 0; k < n; k++)
      v |= longint'(mm[a + k]) << (8 * k);
    if (sg && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 1);
    return v[31:0];
  endfunction

  function automatic logic ref_fault(logic we,
                                     logic [31:0] a,
                                     logic [1:0] sz);
    logic inr = (a - BASE) < 32'h0002_0000;
    logic tx  = a == TXA;
    logic st  = a == STA;
    logic mis = sz != 2'd3 && (a % (32'd1 << sz)) != 0;
    return sz == 2'd3 || mis || !(inr || tx || st) ||
           (tx && !we) || (st && we);
  endfunction

  task automatic issue(logic we, logic [31:0] a,
                       logic [31:0] d, logic [1:0] sz,
                       logic sg, logic clr);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a;
    req_wdata = d; req_size = sz; req_signed = sg;
    fault_clr = clr;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got ready=0 expected 1 at %h", a);
    end
    @(posedge clk);
    #1 req_valid = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic load_chk(string nm, logic [31:0] a,
                          logic [1:0] sz, logic sg,
                          logic [31:0] exp);
    issue(1'b0, a, 32'd0, sz, sg, 1'b0);
    @(negedge clk);
    chk({nm, "_v"}, rsp_valid, 1);
    chk(nm, rsp_rdata, exp);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] exp;
    logic        ef;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [31:0] last_dat, exp_dat, a, d;
    logic exp_rsp, we, sg, v, acc, pop, bd, full;
    logic [1:0] sz;
    int got, c;

    tbl.push_back('{1'b1, BASE+32'h3,  32'h80,       2'd0, 1'b0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, BASE+32'h3,  32'h0,        2'd0, 1'b1, 32'hFFFF_FF80, 1'b0});
    tbl.push_back('{1'b0, BASE+32'h3,  32'h0,        2'd0, 1'b0, 32'h0000_0080, 1'b0});
    tbl.push_back('{1'b1, BASE+32'h10, 32'h1234_5678, 2'd2, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, BASE+32'h12, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, BASE+32'h10, 32'h0,        2'd2, 1'b0, 32'hBEEF_5678, 1'b0});
    tbl.push_back('{1'b0, BASE+32'h12, 32'h0,        2'd1, 1'b1, 32'hFFFF_BEEF, 1'b0});
    tbl.push_back('{1'b0, BASE+32'h12, 32'h0,        2'd1, 1'b0, 32'h0000_BEEF, 1'b0});
    tbl.push_back('{1'b0, BASE+32'h11, 32'h0,        2'd0, 1'b1, 32'h0000_0056, 1'b0});
    tbl.push_back('{1'b0, BASE+32'h13, 32'h0,        2'd0, 1'b1, 32'hFFFF_FFBE, 1'b0});
    tbl.push_back('{1'b1, BASE+32'h1FFFC, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0,     1'b0});
    tbl.push_back('{1'b0, BASE+32'h1FFFC, 32'h0,     2'd2, 1'b0, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b0, BASE+32'h20000, 32'h0,     2'd2, 1'b0, 32'h0,         1'b1});

    // Reset state
    #1;
    chk("rst_rsp_v", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_fault", fault, 0);
    chk("rst_faddr", fault_addr, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    foreach (tbl[i]) begin
      issue(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].sz,
            tbl[i].sg, 1'b0);
      if (tbl[i].we) mstore(tbl[i].a, tbl[i].d, tbl[i].sz);
      @(negedge clk);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_st_v", i), rsp_valid, 0);
      end else begin
        chk($sformatf("vec%0d_v", i), rsp_valid, 1);
        chk($sformatf("vec%0d_rd", i), rsp_rdata, tbl[i].exp);
      end
      chk($sformatf("vec%0d_flt", i), fault, tbl[i].ef);
    end
    chk("vec_faddr", fault_addr, BASE + 32'h20000);
    @(negedge clk) fault_clr = 1'b1;
    @(posedge clk) #1 fault_clr = 1'b0;
    @(negedge clk);
    chk("vec_clr", fault, 0);

    // Load directly behind a store to the same word
    issue(1'b1, BASE + 32'h20, 32'hA5A5_1234, SZ_W, 1'b0, 1'b0);
    mstore(BASE + 32'h20, 32'hA5A5_1234, SZ_W);
    load_chk("raw", BASE + 32'h20, SZ_W, 1'b0, 32'hA5A5_1234);
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("rsp_hold", rsp_rdata, 32'hA5A5_1234);

    // Queue fill, stall, status and drain
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1)
        issue(1'b1, TXA, {24'hABCDEF, 8'h41 + 8'(i)}, SZ_W, 1'b0, 1'b0);
      else
        issue(1'b1, TXA, 32'h41 + i, SZ_B, 1'b0, 1'b0);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = TXA;
    req_wdata = 32'h49; req_size = SZ_B;
    #1 chk("q_full_stall", req_ready, 0);
    req_valid = 1'b0;
    chk("q_head_v", tx_valid, 1);
    chk("q_head_d", tx_data, 32'h41);
    load_chk("q_stat_full", STA, SZ_W, 1'b0, 32'h22);
    @(negedge clk);
    tx_ready = 1'b1; req_valid = 1'b1;
    req_we = 1'b1; req_addr = TXA; req_wdata = 32'h49;
    req_size = SZ_B;
    #1 chk("q_full_pop_stall", req_ready, 0);
    fork
      begin
        int n = 0;
        while (!req_ready && n < 20) begin
          @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
          checks++; errors++;
          $display("FAIL q_stall_timeout: got ready=0 expected 1");
        end
        @(posedge clk); #1 req_valid = 1'b0;
      end
      begin
        int n = 0;
        got = 0;
        while (got < 9 && n < 40) begin
          if (tx_valid) begin
            chk($sformatf("q_drain%0d", got), tx_data, 32'h41 + got);
            got++;
          end
          @(negedge clk); n++;
        end
        if (got < 9) begin
          checks++; errors++;
          $display("FAIL q_drain_timeout: got %0d expected 9", got);
        end
      end
    join
    tx_ready = 1'b0;
    @(negedge clk);
    chk("q_empty", tx_valid, 0);
    load_chk("q_stat_empty", STA, SZ_W, 1'b0, 32'h01);

    // Fault capture and clear
    load_chk("f_mis_lw", BASE + 32'h2, SZ_W, 1'b0, 32'h0);
    chk("f_set", fault, 1);
    chk("f_addr", fault_addr, BASE + 32'h2);
    issue(1'b1, 32'h3000_0000, 32'h0, SZ_W, 1'b0, 1'b0);
    @(negedge clk);
    chk("f_sticky", fault, 1);
    chk("f_addr_kept", fault_addr, BASE + 32'h2);
    issue(1'b1, BASE + 32'h11, 32'hFFFF_FFFF, SZ_W, 1'b0, 1'b0);
    load_chk("f_no_write", BASE + 32'h10, SZ_W, 1'b0, 32'hBEEF_5678);
    issue(1'b1, TXA, 32'h5A, SZ_X, 1'b0, 1'b0);
    @(negedge clk);
    chk("f_no_push", tx_valid, 0);
    load_chk("f_ld_tx", TXA, SZ_W, 1'b0, 32'h0);
    issue(1'b0, 32'h4000_0000, 32'h0, SZ_B, 1'b0, 1'b1);
    @(negedge clk);
    chk("f_clr_new", fault, 1);
    chk("f_clr_new_addr", fault_addr, 32'h4000_0000);
    chk("f_clr_new_rd", rsp_rdata, 0);
    @(negedge clk) fault_clr = 1'b1;
    @(posedge clk) #1 fault_clr = 1'b0;
    @(negedge clk);
    chk("f_clr", fault, 0);

    // Reset with queued bytes and a pending response
    for (int i = 0; i < 3; i++)
      issue(1'b1, TXA, 32'h61 + i, SZ_B, 1'b0, 1'b0);
    issue(1'b0, BASE + 32'h10, 32'h0, SZ_W, 1'b0, 1'b0);
    chk("rr_pending", rsp_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_txv", tx_valid, 0);
    chk("rr_txd", tx_data, 0);
    chk("rr_rsp_v", rsp_valid, 0);
    chk("rr_rdata", rsp_rdata, 0);
    chk("rr_ready", req_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    load_chk("rr_ram0", BASE + 32'h10, SZ_W, 1'b0, 32'hBEEF_5678);
    load_chk("rr_ram1", BASE + 32'h20, SZ_W, 1'b0, 32'hA5A5_1234);

    // Randomized run against the model
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      issue(1'b1, BASE + 32'(4 * w), d, SZ_W, 1'b0, 1'b0);
      mstore(BASE + 32'(4 * w), d, SZ_W);
    end
    mf = 1'b0; mfa = '0; txq = {};
    exp_rsp = 1'b0; last_dat = 32'hA5A5_1234;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      chk("r_rsp_v", rsp_valid, exp_rsp);
      chk("r_rdata", rsp_rdata, last_dat);
      chk("r_txv", tx_valid, txq.size() != 0);
      if (txq.size() != 0) chk("r_txd", tx_data, txq[0]);
      chk("r_fault", fault, mf);
      if (mf) chk("r_faddr", fault_addr, mfa);

      tx_ready  = $urandom_range(0, 1) == 1;
      fault_clr = $urandom_range(0, 19) == 0;
      v  = $urandom_range(0, 3) != 0;
      sg = $urandom_range(0, 1) == 1;
      d  = $urandom;
      c  = $urandom_range(0, 9);
      if (c <= 5) begin
        a  = BASE + $urandom_range(0, 63);
        we = $urandom_range(0, 1) == 1;
        got = $urandom_range(0, 7);
        sz = got < 3 ? SZ_B : got < 5 ? SZ_H : got < 7 ? SZ_W : SZ_X;
      end else if (c <= 7) begin
        a  = TXA;
        we = $urandom_range(0, 4) != 0;
        sz = $urandom_range(0, 1) == 1 ? SZ_W : SZ_B;
      end else if (c == 8) begin
        a  = STA;
        we = $urandom_range(0, 3) == 0;
        sz = SZ_W;
      end else begin
        got = $urandom_range(0, 3);
        a = got == 0 ? BASE - 32'd4 :
            got == 1 ? BASE + 32'h2_0000 :
            got == 2 ? 32'h3000_0000 | ($urandom & 32'hFFC) :
                       32'h2000_0008;
        we = $urandom_range(0, 1) == 1;
        sz = SZ_W;
      end
      req_valid = v; req_we = we; req_addr = a;
      req_wdata = d; req_size = sz; req_signed = sg;

      full = txq.size() == 8;
      #1 chk("r_ready", req_ready,
             !(v && we && a == TXA && full));
      acc = v && !(we && a == TXA && full);
      pop = txq.size() != 0 && tx_ready;
      bd  = ref_fault(we, a, sz);
      exp_rsp = acc && !we;
      if (exp_rsp) begin
        if (bd) exp_dat = 32'h0;
        else if (a == STA)
          exp_dat = 32'(txq.size()) * 4 + (full ? 2 : 0) +
                    (txq.size() == 0 ? 1 : 0);
        else exp_dat = ref_load(a, sz, sg);
        last_dat = exp_dat;
      end
      if (acc && bd) begin
        if (!mf || fault_clr) mfa = a;
        mf = 1'b1;
      end else if (fault_clr) begin
        mf = 1'b0;
      end
      if (pop) void'(txq.pop_front());
      if (acc && we && !bd) begin
        if (a == TXA) txq.push_back(d[7:0]);
        else mstore(a, d, sz);
      end
    end
    @(negedge clk);
    req_valid = 1'b0; fault_clr = 1'b0;
    chk("r_end_rsp_v", rsp_valid, exp_rsp);
    chk("r_end_rdata", rsp_rdata, last_dat);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
